ce_pilot_inserter: RTL and testbench
====================================

Name: ce_pilot_inserter

Overview:
Transmit-side framer that produces the complex sample stream the CE channel estimator consumes. Each frame is NUM_PILOTS known pilot symbols followed by FRAME_LEN payload samples taken from an upstream valid/ready source. The pilot sequence comes from an LFSR that restarts every frame, so the receiver-side CE always sees identical training symbols.

Parameters:
DATA_WIDTH, 40, width of each real/imag component (two's complement, matches CE sample width)
NUM_PILOTS, 4, pilot symbols per frame (1..127)
FRAME_LEN, 64, payload samples per frame (1..65535)
PILOT_AMP, 16777216, pilot magnitude (1.0 in Q15.24); must be < 2^(DATA_WIDTH-1)

Ports:
clk  input  1  clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
enable  input  1  start frames while high; a frame in progress always completes
in_valid  input  1  upstream payload sample valid
in_ready  output  1  upstream payload sample accepted when in_valid && in_ready
in_real  input  DATA_WIDTH  payload real part
in_imag  input  DATA_WIDTH  payload imag part
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_real  output  DATA_WIDTH  output real part
out_imag  output  DATA_WIDTH  output imag part
out_pilot  output  1  current output is a pilot
out_sof  output  1  current output is the first sample of a frame

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE, out_valid=0, out_real=0, out_imag=0, out_pilot=0, out_sof=0, in_ready=0, LFSR=7'h7F, counters=0. Reset has priority over all other events, including mid-frame: the partial frame is dropped and any held output is discarded.
- Output register: a single stage. slot_free = !out_valid || out_ready. While out_valid && !out_ready, all out_* hold stable and no state advances.
- States:
  - IDLE: if enable && slot_free, go to PILOT and emit pilot 0 on that edge with out_sof=1.
  - PILOT: each edge with slot_free emits one pilot. After the NUM_PILOTS-th pilot is loaded, go to DATA.
  - DATA: in_ready = slot_free (combinational). Each accepted input loads out_real=in_real and out_imag=in_imag unchanged, with out_pilot=0 and out_sof=0. After the FRAME_LEN-th accept: if enable, go to PILOT; otherwise go to IDLE.
- Back-to-back frames: when enable stays high, pilot 0 of the next frame is loaded on the edge after the last payload sample. There is no gap cycle.
- In DATA, when slot_free && !in_valid, out_valid drops to 0. Bubbles pass through; nothing is filled in.
- in_ready is 0 in IDLE and PILOT.
- Pilot generation: LFSR x^7+x^6+1. bit=lfsr[6]. Next state is {lfsr[5:0], lfsr[6]^lfsr[5]}, stepped once per emitted pilot.
- Pilot value: out_real=+PILOT_AMP if bit==1, else -PILOT_AMP (two's complement). out_imag=0. out_pilot=1.
- The LFSR reloads 7'h7F at the start of every frame, so all frames carry the same pilot sequence.
- Latency: one cycle from an input handshake to the corresponding out_valid.
- Throughput: one sample per cycle with out_ready held at 1.
- enable deasserted mid-frame: no effect until the frame ends.
- enable deasserted in IDLE: stay in IDLE.
- Payload counter: width ceil(log2(FRAME_LEN+1)), no wrap within a frame.
- Pilot counter: 7 bits.
- Both counters clear at frame start.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with enable=1 and in_valid=1 -> all outputs 0, in_ready=0. Release reset -> pilot 0 with out_sof=1 appears on the 1st edge after release.
2. NUM_PILOTS=8, FRAME_LEN=4, out_ready=1, in_valid=1, payload real=1,2,3,4 -> out_real = +16777216 (x7), -16777216, then 1,2,3,4. Imag is 0 on all pilots. out_pilot=1 on exactly 8 samples.
3. enable held high for 3 frames -> every frame carries identical pilots. Samples are contiguous with no idle cycle between frames. out_sof=1 exactly 3 times.
4. Backpressure: drop out_ready for 5 cycles during both PILOT and DATA -> out_* held stable, in_ready=0 throughout, no sample lost or duplicated, and the final sequence matches test 2.
5. Bubble handling: drop in_valid for 3 cycles mid-DATA -> out_valid=0 for 3 cycles, frame still ends after exactly FRAME_LEN payload samples. Drop enable mid-frame -> frame completes, then IDLE.
6. Reset mid-frame: assert reset after the 2nd payload sample -> next edge gives out_valid=0 and IDLE. After release, the new frame starts with out_sof=1 and pilot 0 = +16777216.

Source files
------------

// File: rtl/ce_pilot_inserter.sv
// ce_pilot_inserter
// Transmit-side framer feeding the CE channel estimator. Every frame is
// NUM_PILOTS LFSR-derived BPSK pilot symbols (+/-PILOT_AMP on the real rail)
// followed by FRAME_LEN payload samples pulled from a valid/ready source.
// The pilot LFSR reloads at each frame start, so every frame carries the
// same training sequence.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   enable          start new frames while high; a running frame always completes
//   in_valid/ready  upstream payload handshake (in_ready is combinational)
//   in_real/imag    payload sample, DATA_WIDTH two's complement per rail
//   out_valid/ready downstream handshake, single registered output stage
//   out_real/imag   output sample
//   out_pilot       output sample is a pilot
//   out_sof         output sample is the first of a frame
module ce_pilot_inserter #(
    parameter int unsigned     DATA_WIDTH = 40,
    parameter int unsigned     NUM_PILOTS = 4,
    parameter int unsigned     FRAME_LEN  = 64,
    parameter longint unsigned PILOT_AMP  = 64'd16777216
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_real,
    input  logic [DATA_WIDTH-1:0] in_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic                  out_pilot,
    output logic                  out_sof
);

    localparam int unsigned PAY_CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned PIL_CNT_W = 7;
    localparam int unsigned LFSR_W    = 7;

    localparam logic [LFSR_W-1:0]     LFSR_SEED = 7'h7F;
    localparam logic [DATA_WIDTH-1:0] AMP_POS   = DATA_WIDTH'(PILOT_AMP);
    localparam logic [DATA_WIDTH-1:0] AMP_NEG   = ~AMP_POS + DATA_WIDTH'(1);
    localparam logic [PIL_CNT_W-1:0]  PIL_LAST  = PIL_CNT_W'(NUM_PILOTS - 1);
    localparam logic [PAY_CNT_W-1:0]  PAY_LAST  = PAY_CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PILOT = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
    logic [PIL_CNT_W-1:0]    pilot_cnt_q, pilot_cnt_d;
    logic [PAY_CNT_W-1:0]    pay_cnt_q, pay_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_real_q, out_real_d;
    logic [DATA_WIDTH-1:0]   out_imag_q, out_imag_d;
    logic                    out_pilot_q, out_pilot_d;
    logic                    out_sof_q, out_sof_d;
    logic                    slot_free;

    // State and output register; reset drops any partial frame and held output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            pilot_cnt_q <= '0;
            pay_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_pilot_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pilot_cnt_q <= pilot_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_pilot_q <= out_pilot_d;
            out_sof_q   <= out_sof_d;
        end
    end

    // Next-state, framing and output-stage load logic.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        pilot_cnt_d = pilot_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        out_valid_d = out_valid_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_pilot_d = out_pilot_q;
        out_sof_d   = out_sof_q;
        in_ready    = 1'b0;

        // Output stage can take a new sample when empty or being drained.
        slot_free = !out_valid_q || out_ready;

        case (state_q)
            // IDLE and PILOT share the pilot emitter; counters and LFSR are
            // already at their frame-start values whenever IDLE is entered.
            ST_IDLE, ST_PILOT: begin
                if (slot_free) begin
                    if (state_q == ST_PILOT || enable) begin
                        out_valid_d = 1'b1;
                        out_real_d  = lfsr_q[LFSR_W-1] ? AMP_POS : AMP_NEG;
                        out_imag_d  = '0;
                        out_pilot_d = 1'b1;
                        out_sof_d   = (pilot_cnt_q == '0);
                        lfsr_d      = {lfsr_q[LFSR_W-2:0], lfsr_q[6] ^ lfsr_q[5]};
                        pilot_cnt_d = pilot_cnt_q + PIL_CNT_W'(1);
                        state_d     = (pilot_cnt_q == PIL_LAST) ? ST_DATA : ST_PILOT;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end

            ST_DATA: begin
                // Gated by reset so nothing upstream is consumed on a reset edge.
                in_ready = reset && slot_free;
                if (slot_free) begin
                    if (in_valid) begin
                        out_valid_d = 1'b1;
                        out_real_d  = in_real;
                        out_imag_d  = in_imag;
                        out_pilot_d = 1'b0;
                        out_sof_d   = 1'b0;
                        pay_cnt_d   = pay_cnt_q + PAY_CNT_W'(1);
                        if (pay_cnt_q == PAY_LAST) begin
                            // Frame done: rearm for an identical pilot sequence.
                            lfsr_d      = LFSR_SEED;
                            pilot_cnt_d = '0;
                            pay_cnt_d   = '0;
                            state_d     = enable ? ST_PILOT : ST_IDLE;
                        end
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_pilot = out_pilot_q;
    assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_ce_pilot_inserter.sv
// Testbench for ce_pilot_inserter: directed table for one frame, hand-written
// sequences for backpressure, bubbles and resets, then randomized traffic
// checked by a stream-level scoreboard (pilot list + accepted-payload queue).
module tb_ce_pilot_inserter;

    localparam int unsigned DW = 40;
    localparam int unsigned NP = 8;
    localparam int unsigned FL = 4;

    localparam logic [DW-1:0] POS = 40'd16777216;
    localparam logic [DW-1:0] NEG = 40'hFF_FF00_0000;
    localparam logic [DW-1:0] M1  = 40'hFF_FFFF_FFFF;
    localparam logic [DW-1:0] M2  = 40'hFF_FFFF_FFFE;
    localparam logic [DW-1:0] M3  = 40'hFF_FFFF_FFFD;
    localparam logic [DW-1:0] M4  = 40'hFF_FFFF_FFFC;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real;
    logic [DW-1:0] in_imag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic          out_pilot;
    logic          out_sof;

    ce_pilot_inserter #(
        .DATA_WIDTH(DW),
        .NUM_PILOTS(NP),
        .FRAME_LEN (FL),
        .PILOT_AMP (64'd16777216)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_real (out_real),
        .out_imag (out_imag),
        .out_pilot(out_pilot),
        .out_sof  (out_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    // ---------------- stream-level reference model ----------------
    logic [DW-1:0] pilot_tab[NP];
    logic [DW-1:0] pq_re[$];
    logic [DW-1:0] pq_im[$];
    logic [DW-1:0] got_re[$];
    logic [DW-1:0] got_im[$];
    int            pos = 0;
    int            sof_cnt = 0;
    int            hs_cnt = 0;
    logic          stall_prev = 1'b0;
    logic          lat_pend = 1'b0;
    logic [DW-1:0] sv_re, sv_im, e_re, e_im;
    logic          sv_p, sv_s, e_p, e_s, e_ok;

    always @(negedge clk) begin
        if (!reset) begin
            pq_re.delete();
            pq_im.delete();
            pos        = 0;
            stall_prev = 1'b0;
            lat_pend   = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_real", 64'(out_real), 64'(sv_re));
                chk("hold_imag", 64'(out_imag), 64'(sv_im));
                chk("hold_pilot", 64'(out_pilot), 64'(sv_p));
                chk("hold_sof", 64'(out_sof), 64'(sv_s));
            end
            if (lat_pend) chk("latency_valid", 64'(out_valid), 64'd1);
            if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (out_sof) sof_cnt++;
                got_re.push_back(out_real);
                got_im.push_back(out_imag);
                e_ok = 1'b1;
                if (pos < int'(NP)) begin
                    e_re = pilot_tab[pos];
                    e_im = '0;
                    e_p  = 1'b1;
                    e_s  = (pos == 0);
                end else if (pq_re.size() == 0) begin
                    e_ok = 1'b0;
                end else begin
                    e_re = pq_re.pop_front();
                    e_im = pq_im.pop_front();
                    e_p  = 1'b0;
                    e_s  = 1'b0;
                end
                chk("sb_payload_avail", 64'(e_ok), 64'd1);
                if (e_ok) begin
                    chk("sb_real", 64'(out_real), 64'(e_re));
                    chk("sb_imag", 64'(out_imag), 64'(e_im));
                    chk("sb_pilot", 64'(out_pilot), 64'(e_p));
                    chk("sb_sof", 64'(out_sof), 64'(e_s));
                end
                pos = (pos + 1 == int'(NP + FL)) ? 0 : pos + 1;
            end
            lat_pend = in_valid && in_ready;
            if (lat_pend) begin
                pq_re.push_back(in_real);
                pq_im.push_back(in_imag);
            end
            stall_prev = out_valid && !out_ready;
            sv_re = out_real;
            sv_im = out_imag;
            sv_p  = out_pilot;
            sv_s  = out_sof;
        end
    end

    // One clock: drive at posedge+1, sample in_ready mid-cycle, return at next posedge+1.
    task automatic cycle(input logic en, input logic iv, input logic ordy, input logic rst,
                         input logic [DW-1:0] d, output logic ir);
        enable    = en;
        in_valid  = iv;
        out_ready = ordy;
        reset     = rst;
        in_real   = d;
        in_imag   = DW'(0) - d;
        #2;
        ir = in_ready;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] in_real;
        logic          exp_ir;
        logic [DW-1:0] exp_real;
        logic [DW-1:0] exp_imag;
        logic          exp_pilot;
        logic          exp_sof;
    } vec_t;

    vec_t          vec[12];
    logic          ir;
    logic          en_r, iv_r, or_r, rs_r;
    int            gaps;
    int            zcnt;
    int            pay;
    int            hs_start;
    logic [6:0]    s;

    initial begin
        reset = 1'b0; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_real = '0; in_imag = '0;

        s = 7'h7F;
        for (int k = 0; k < int'(NP); k++) begin
            pilot_tab[k] = s[6] ? POS : NEG;
            s = {s[5:0], s[6] ^ s[5]};
        end

        vec[0]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b1};
        vec[1]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b0};
        vec[2]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b0};
        vec[3]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b0};
        vec[4]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b0};
        vec[5]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b0};
        vec[6]  = '{40'd1, 1'b0, POS,   40'd0, 1'b1, 1'b0};
        vec[7]  = '{40'd1, 1'b0, NEG,   40'd0, 1'b1, 1'b0};
        vec[8]  = '{40'd1, 1'b1, 40'd1, M1,    1'b0, 1'b0};
        vec[9]  = '{40'd2, 1'b1, 40'd2, M2,    1'b0, 1'b0};
        vec[10] = '{40'd3, 1'b1, 40'd3, M3,    1'b0, 1'b0};
        vec[11] = '{40'd4, 1'b1, 40'd4, M4,    1'b0, 1'b0};

        @(posedge clk);
        #1;

        // Reset held with enable and in_valid high
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd7, ir);
            chk("rst_in_ready", 64'(ir), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_real", 64'(out_real), 64'd0);
            chk("rst_out_imag", 64'(out_imag), 64'd0);
            chk("rst_out_pilot", 64'(out_pilot), 64'd0);
            chk("rst_out_sof", 64'(out_sof), 64'd0);
        end

        // One full frame from the vector table
        sof_cnt = 0;
        gaps = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, vec[i].in_real, ir);
            chk("vec_in_ready", 64'(ir), 64'(vec[i].exp_ir));
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_real", 64'(out_real), 64'(vec[i].exp_real));
            chk("vec_imag", 64'(out_imag), 64'(vec[i].exp_imag));
            chk("vec_pilot", 64'(out_pilot), 64'(vec[i].exp_pilot));
            chk("vec_sof", 64'(out_sof), 64'(vec[i].exp_sof));
        end

        // Two more back-to-back frames, enable dropped during the third
        for (int k = 0; k < 24; k++) begin
            cycle(k < 14, 1'b1, 1'b1, 1'b1, rnd_data(), ir);
            if (!out_valid) gaps++;
        end
        chk("b2b_gap_cycles", 64'(gaps), 64'd0);
        chk("b2b_sof_count", 64'(sof_cnt), 64'd3);
        chk("b2b_last_is_payload", 64'(out_pilot), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, rnd_data(), ir);
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_in_ready", 64'(ir), 64'd0);
        end

        // Backpressure in PILOT and in DATA
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd0, ir);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd0, ir);
        got_re.delete();
        got_im.delete();
        pay = 1;
        for (int st = 0; st < 30; st++) begin
            or_r = !((st >= 2 && st <= 6) || (st >= 15 && st <= 19));
            cycle(st < 2, 1'b1, or_r, 1'b1, DW'(pay), ir);
            if (!or_r) chk("bp_in_ready", 64'(ir), 64'd0);
            if (ir) pay++;
        end
        chk("bp_sample_count", 64'(got_re.size()), 64'd12);
        chk("bp_inputs_taken", 64'(pay), 64'd5);
        for (int i = 0; i < 12 && i < got_re.size(); i++) begin
            chk("bp_seq_real", 64'(got_re[i]), 64'(vec[i].exp_real));
            chk("bp_seq_imag", 64'(got_im[i]), 64'(vec[i].exp_imag));
        end

        // Bubbles mid-DATA and enable dropped mid-frame
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd0, ir);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd0, ir);
        pay = 1;
        zcnt = 0;
        sof_cnt = 0;
        for (int st = 0; st < 15; st++) begin
            iv_r = !(st >= 10 && st <= 12);
            cycle(st < 9, iv_r, 1'b1, 1'b1, DW'(pay), ir);
            if (iv_r && ir) pay++;
            if (!out_valid) zcnt++;
        end
        chk("bubble_zero_cycles", 64'(zcnt), 64'd3);
        chk("bubble_last_valid", 64'(out_valid), 64'd1);
        chk("bubble_last_real", 64'(out_real), 64'd4);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, DW'(pay), ir);
            chk("bubble_idle_valid", 64'(out_valid), 64'd0);
        end
        chk("bubble_inputs_taken", 64'(pay), 64'd5);
        chk("bubble_sof_count", 64'(sof_cnt), 64'd1);

        // Reset after the second payload sample
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd0, ir);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 40'd0, ir);
        pay = 1;
        for (int st = 0; st < 10; st++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, DW'(pay), ir);
            if (ir) pay++;
        end
        chk("mid_pre_real", 64'(out_real), 64'd2);
        chk("mid_pre_pilot", 64'(out_pilot), 64'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, DW'(pay), ir);
        chk("mid_rst_in_ready", 64'(ir), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sof", 64'(out_sof), 64'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, DW'(pay), ir);
        chk("mid_restart_in_ready", 64'(ir), 64'd0);
        chk("mid_restart_valid", 64'(out_valid), 64'd1);
        chk("mid_restart_sof", 64'(out_sof), 64'd1);
        chk("mid_restart_pilot", 64'(out_pilot), 64'd1);
        chk("mid_restart_real", 64'(out_real), 64'(POS));
        chk("mid_restart_imag", 64'(out_imag), 64'd0);

        // Randomized traffic against the scoreboard
        hs_start = hs_cnt;
        for (int n = 0; n < 3000; n++) begin
            en_r = ($urandom_range(0, 9) != 0);
            iv_r = ($urandom_range(0, 3) != 0);
            or_r = ($urandom_range(0, 3) != 0);
            rs_r = ($urandom_range(0, 299) != 0);
            cycle(en_r, iv_r, or_r, rs_r, rnd_data(), ir);
        end
        chk("rand_traffic_flowed", 64'((hs_cnt - hs_start) > 500), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
